rf_write_ctrl: RTL and testbench

//  Write-side controller for the 32x32 register file: the sole driver of its we/waddr/wdata port.

---
 rtl/rf_pkg.sv | 11 +
 rtl/wb_sync_fifo.sv | 55 +++++
 rtl/rf_write_ctrl.sv | 130 +++++++++++++
 tb/tb_rf_write_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and sizes for the write-back path.
package rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM    = 32;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [XLEN-1:0]      data;
  } wb_req_t;
endpackage

// File: rtl/wb_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of 2).
module wb_sync_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(wb_req_t)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: contents are only observable below r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end
endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port owner: arbitrates the ALU path (A) against the
// buffered long-latency path (B) and tracks pending B writes per register.
module rf_write_ctrl
  import rf_pkg::*;
#(
  parameter int B_DEPTH    = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [RF_ADDR_W-1:0]     a_addr,
  input  logic [XLEN-1:0]          a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [RF_ADDR_W-1:0]     b_addr,
  input  logic [XLEN-1:0]          b_data,
  output logic                     rf_we,
  output logic [RF_ADDR_W-1:0]     rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  input  logic [RF_ADDR_W-1:0]     q_raddr1,
  output logic                     q_busy1,
  input  logic [RF_ADDR_W-1:0]     q_raddr2,
  output logic                     q_busy2,
  output logic [$clog2(B_DEPTH):0] b_count
);
  localparam int CW = $clog2(B_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  wb_req_t             w_b_in;
  wb_req_t             w_b_head;
  logic                w_b_push;
  logic                w_b_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_starve_ovr;
  logic                w_take_a;
  logic [RF_NUM-1:0]   w_sb_inc;
  logic [RF_NUM-1:0]   w_sb_dec;

  logic [SW-1:0]        r_starve;
  logic                 r_we;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]      r_wdata;
  logic                 r_from_b;
  logic [CW-1:0]        r_sb_cnt [RF_NUM];

  assign w_b_in   = '{addr: b_addr, data: b_data};
  assign b_ready  = !w_fifo_full;
  assign w_b_push = b_valid && b_ready && (b_addr != '0);

  wb_sync_fifo #(
    .DEPTH (B_DEPTH),
    .WIDTH ($bits(wb_req_t))
  ) u_b_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_b_push),
    .i_wdata (w_b_in),
    .i_pop   (w_b_pop),
    .o_rdata (w_b_head),
    .o_count (b_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A starved FIFO head steals the write slot from A for one cycle.
  assign w_starve_ovr = (r_starve == SW'(STARVE_MAX)) && !w_fifo_empty;
  assign a_ready      = !w_starve_ovr;
  assign w_take_a     = a_valid && a_ready;
  assign w_b_pop      = !w_fifo_empty && (w_starve_ovr || !a_valid);

  always_ff @(posedge clk) begin
    if (reset || w_b_pop || w_fifo_empty) begin
      r_starve <= '0;
    end else if (a_valid && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Output stage: register the winner; an A write to r0 burns the slot silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_from_b <= 1'b0;
    end else if (w_take_a && (a_addr != '0)) begin
      r_we     <= 1'b1;
      r_waddr  <= a_addr;
      r_wdata  <= a_data;
      r_from_b <= 1'b0;
    end else if (w_b_pop) begin
      r_we     <= 1'b1;
      r_waddr  <= w_b_head.addr;
      r_wdata  <= w_b_head.data;
      r_from_b <= 1'b1;
    end else begin
      r_we     <= 1'b0;
      r_from_b <= 1'b0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  // Scoreboard: count B writes between FIFO push and their rf_we cycle.
  always_comb begin
    w_sb_inc = '0;
    w_sb_dec = '0;
    if (w_b_push)          w_sb_inc[b_addr]  = 1'b1;
    if (r_we && r_from_b)  w_sb_dec[r_waddr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RF_NUM; i++) r_sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < RF_NUM; i++) begin
        if (w_sb_inc[i] && !w_sb_dec[i])      r_sb_cnt[i] <= r_sb_cnt[i] + CW'(1);
        else if (w_sb_dec[i] && !w_sb_inc[i]) r_sb_cnt[i] <= r_sb_cnt[i] - CW'(1);
      end
    end
  end

  assign q_busy1 = (r_sb_cnt[q_raddr1] != '0);
  assign q_busy2 = (r_sb_cnt[q_raddr2] != '0);
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed bench for rf_write_ctrl: handshakes feed an expected-write scoreboard,
// a negedge monitor checks every rf_we, and the stimulus adds directed checks.
module tb_rf_write_ctrl;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, a_ready;
  logic [4:0]  a_addr = '0;
  logic [31:0] a_data = '0;
  logic        b_valid = 1'b0, b_ready;
  logic [4:0]  b_addr = '0;
  logic [31:0] b_data = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_raddr1 = '0, q_raddr2 = '0;
  logic        q_busy1, q_busy2;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  rf_write_ctrl #(.B_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_raddr1(q_raddr1), .q_busy1(q_busy1), .q_raddr2(q_raddr2), .q_busy2(q_busy2),
    .b_count(b_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t qb[$];
  exp_t a_pend;
  bit   a_due = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: check this cycle's write, then capture handshakes for the next edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (a_due) begin
      n_cmp++;
      if (!(rf_we === 1'b1 && rf_waddr === a_pend.addr && rf_wdata === a_pend.data)) begin
        n_bad++;
        $display("FAIL a_commit: got we=%0b addr=%0d data=%0h, expected we=1 addr=%0d data=%0h",
                 rf_we, rf_waddr, rf_wdata, a_pend.addr, a_pend.data);
      end
    end else if (rf_we === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_write: got addr=%0d data=%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = qb.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          n_bad++;
          $display("FAIL b_commit: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
    a_due = 1'b0;
    if (reset) begin
      qb.delete();
    end else begin
      if (a_valid && a_ready && a_addr != 5'd0) begin
        a_due  = 1'b1;
        a_pend = '{addr: a_addr, data: a_data};
      end
      if (b_valid && b_ready && b_addr != 5'd0) qb.push_back('{addr: b_addr, data: b_data});
    end
  end

  initial begin : timeout
    #50000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int nlow;
    int commit_at;
    int nwe;

    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_bcount", b_count, 0);
    chk("rst_bready", b_ready, 1);
    chk("rst_aready", a_ready, 1);
    chk("rst_busy1", q_busy1, 0);

    // 1: single A write, one-cycle latency, one-cycle pulse
    step();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
    @(negedge clk);
    chk("t1_aready", a_ready, 1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    @(negedge clk);
    chk("t1_we_drop", rf_we, 0);

    // 2: fill FIFO behind continuous A traffic; each head overrides after 8 waits
    step();
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_addr = 5'(i + 1); b_data = 32'hB1 + 32'(i);
      step();
    end
    b_valid = 1'b0;
    @(negedge clk);
    chk("t2_bcount_full", b_count, 4);
    chk("t2_bready_full", b_ready, 0);
    nlow = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_ready !== 1'b1) nlow++;
    end
    chk("t2_overrides", nlow, 4);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("t2_bcount_drained", b_count, 0);

    // 3: single B behind continuous A: one override, commit registered 9 edges after push
    step();
    a_valid = 1'b1; a_addr = 5'd11; a_data = 32'hC0;
    b_valid = 1'b1; b_addr = 5'd9;  b_data = 32'hDEAD_BEEF;
    step();
    b_valid = 1'b0;
    nlow = 0;
    commit_at = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (a_ready !== 1'b1) nlow++;
      if (rf_we === 1'b1 && rf_waddr === 5'd9 && commit_at == 0) commit_at = k;
    end
    chk("t3_override_cycles", nlow, 1);
    chk("t3_r9_commit_negedge", commit_at, 10);
    step();
    a_valid = 1'b0;

    // 4: writes to r0 are accepted and dropped
    step();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF_FFFF;
    q_raddr1 = 5'd0;
    @(negedge clk);
    chk("t4_aready", a_ready, 1);
    chk("t4_bready", b_ready, 1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_we", rf_we, 0);
      chk("t4_bcount", b_count, 0);
      chk("t4_busy1", q_busy1, 0);
    end

    // 5: two B writes to r7; busy holds through the second commit cycle
    q_raddr1 = 5'd7; q_raddr2 = 5'd3;
    step();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h71;
    step();
    b_data = 32'h72;
    @(negedge clk);
    chk("t5_busy_n1", q_busy1, 1);
    step();
    b_valid = 1'b0;
    @(negedge clk);
    chk("t5_busy_n2", q_busy1, 1);
    chk("t5_busy2_other", q_busy2, 0);
    @(negedge clk);
    chk("t5_busy_n3", q_busy1, 1);
    @(negedge clk);
    chk("t5_busy_n4", q_busy1, 0);

    // 6: reset with three queued B entries discards them
    q_raddr1 = 5'd20; q_raddr2 = 5'd22;
    step();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hD0;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_addr = 5'(20 + i); b_data = 32'hE0 + 32'(i);
      step();
    end
    b_valid = 1'b0; a_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("t6_pre_bcount", b_count, 3);
    chk("t6_pre_busy1", q_busy1, 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_bcount", b_count, 0);
    chk("t6_busy1", q_busy1, 0);
    chk("t6_busy2", q_busy2, 0);
    chk("t6_we", rf_we, 0);
    nwe = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rf_we !== 1'b0) nwe++;
    end
    chk("t6_no_stale", nwe, 0);

    step(); step();
    chk("end_b_queue_empty", qb.size(), 0);
    chk("end_a_pending", a_due, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
